// File: rtl/sreg_piso_tx.sv
// Parallel-in serial-out transmitter: start bit 0, WIDTH data bits, stop bit 1.
// Ports: sys_clk, sys_rst_n (async, active-high), din/din_valid/din_ready in, sout/busy/done out.
module sreg_piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CW-1:0]    cyc;
  logic [CW-1:0]    cyc_nx;
  logic [NW-1:0]    bitn;
  logic [NW-1:0]    bitn_nx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [WIDTH-1:0] shifted;
  logic             sout_nx;
  logic             busy_nx;
  logic             ready_nx;
  logic             done_nx;
  logic             bit_end;
  logic             head;

  assign bit_end = (cyc == CYC_LAST);

  // The next bit to send always sits at the head end of shreg;
  // it is consumed by shifting toward that end.
  assign head    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    bitn_nx  = bitn;
    shreg_nx = shreg;
    sout_nx  = sout;
    ready_nx = din_ready;
    done_nx  = 1'b0;

    if (state != IDLE) begin
      cyc_nx = bit_end ? '0 : cyc + 1'b1;
    end

    unique case (state)
      IDLE: begin
        ready_nx = 1'b1;
        sout_nx  = 1'b1;
        if (din_valid && din_ready) begin
          state_nx = START;
          shreg_nx = din;
          sout_nx  = 1'b0;
          ready_nx = 1'b0;
          cyc_nx   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          bitn_nx  = '0;
          sout_nx  = head;
          shreg_nx = shifted;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bitn == BIT_LAST) begin
            state_nx = STOP;
            sout_nx  = 1'b1;
          end else begin
            bitn_nx  = bitn + 1'b1;
            sout_nx  = head;
            shreg_nx = shifted;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          ready_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state     <= IDLE;
      cyc       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      sout      <= 1'b1;
      busy      <= 1'b0;
      din_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc_nx;
      bitn      <= bitn_nx;
      shreg     <= shreg_nx;
      sout      <= sout_nx;
      busy      <= busy_nx;
      din_ready <= ready_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_sreg_piso_tx.sv
// Bench for sreg_piso_tx: five parameterisations against a frame-timeline model.
// Ports: none (top-level testbench).
module tb_sreg_piso_tx;

  localparam int N = 5;
  localparam int PW [N] = '{8, 8, 8, 1, 5};
  localparam int PB [N] = '{1, 1, 4, 3, 2};
  localparam int PM [N] = '{1, 0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_a [N];
  logic       dv [N];
  logic       so [N];
  logic       rd [N];
  logic       bz [N];
  logic       dn [N];

  int total = 0;
  int bad   = 0;

  // model state
  logic        e_so [N];
  logic        e_rd [N];
  logic        e_bz [N];
  logic        e_dn [N];
  bit          act [N];
  int          pos [N];
  logic [31:0] wrd [N];

  always #5 clk = ~clk;

  sreg_piso_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) u0 (
    .sys_clk(clk), .sys_rst_n(rst), .din(din_a[0]), .din_valid(dv[0]),
    .din_ready(rd[0]), .sout(so[0]), .busy(bz[0]), .done(dn[0]));

  sreg_piso_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) u1 (
    .sys_clk(clk), .sys_rst_n(rst), .din(din_a[1]), .din_valid(dv[1]),
    .din_ready(rd[1]), .sout(so[1]), .busy(bz[1]), .done(dn[1]));

  sreg_piso_tx #(.WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1'b1)) u2 (
    .sys_clk(clk), .sys_rst_n(rst), .din(din_a[2]), .din_valid(dv[2]),
    .din_ready(rd[2]), .sout(so[2]), .busy(bz[2]), .done(dn[2]));

  sreg_piso_tx #(.WIDTH(1), .BIT_CYCLES(3), .MSB_FIRST(1'b0)) u3 (
    .sys_clk(clk), .sys_rst_n(rst), .din(din_a[3][0:0]), .din_valid(dv[3]),
    .din_ready(rd[3]), .sout(so[3]), .busy(bz[3]), .done(dn[3]));

  sreg_piso_tx #(.WIDTH(5), .BIT_CYCLES(2), .MSB_FIRST(1'b1)) u4 (
    .sys_clk(clk), .sys_rst_n(rst), .din(din_a[4][4:0]), .din_valid(dv[4]),
    .din_ready(rd[4]), .sout(so[4]), .busy(bz[4]), .done(dn[4]));

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Line level for cycle p of a frame carrying word w on instance i.
  function automatic logic bit_at(input int i, input int p,
                                  input logic [31:0] w);
    int k;
    int d;
    k = p / PB[i];
    if (k == 0) return 1'b0;
    if (k > PW[i]) return 1'b1;
    d = k - 1;
    if (PM[i] != 0) d = PW[i] - 1 - d;
    return w[d];
  endfunction

  // Model: expected outputs for the cycle following each edge.
  initial begin
    for (int i = 0; i < N; i++) begin
      e_so[i] = 1'b1; e_rd[i] = 1'b0; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
      act[i] = 1'b0; pos[i] = 0; wrd[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          act[i] = 1'b0;
          e_so[i] = 1'b1; e_rd[i] = 1'b0; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
        end else if (act[i] && (pos[i] + 1 < (PW[i] + 2) * PB[i])) begin
          pos[i]++;
          e_so[i] = bit_at(i, pos[i], wrd[i]);
        end else if (act[i]) begin
          act[i] = 1'b0;
          e_so[i] = 1'b1; e_rd[i] = 1'b1; e_bz[i] = 1'b0; e_dn[i] = 1'b1;
        end else if (e_rd[i] && dv[i]) begin
          act[i] = 1'b1;
          pos[i] = 0;
          wrd[i] = {24'd0, din_a[i]};
          e_so[i] = 1'b0; e_rd[i] = 1'b0; e_bz[i] = 1'b1; e_dn[i] = 1'b0;
        end else begin
          e_so[i] = 1'b1; e_rd[i] = 1'b1; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
        end
      end
    end
  end

  // Every-cycle compare of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d sout", i), 64'(so[i]), 64'(e_so[i]));
        chk($sformatf("u%0d din_ready", i), 64'(rd[i]), 64'(e_rd[i]));
        chk($sformatf("u%0d busy", i), 64'(bz[i]), 64'(e_bz[i]));
        chk($sformatf("u%0d done", i), 64'(dn[i]), 64'(e_dn[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  sv;
    logic [9:0]  sv2;
    logic [10:0] bv;
    logic [10:0] dvv;
    int lo;
    int hi;
    int bc;
    int dc;

    for (int i = 0; i < N; i++) begin
      din_a[i] = '0;
      dv[i] = 1'b0;
    end

    // reset state
    cyc(3);
    chk("rst sout", 64'(so[0]), 64'd1);
    chk("rst ready", 64'(rd[0]), 64'd0);
    chk("rst busy", 64'(bz[0]), 64'd0);
    chk("rst done", 64'(dn[0]), 64'd0);
    #2 rst = 1'b0;
    cyc(1);
    chk("ready after release", 64'(rd[0]), 64'd1);
    cyc(3);

    // A5 MSB first, din changed to 00 mid-frame
    din_a[0] = 8'hA5; dv[0] = 1'b1;
    sv = '0; bv = '0; dvv = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) dv[0] = 1'b0;
      if (k <= 10) sv = {sv[8:0], so[0]};
      bv = {bv[9:0], bz[0]};
      dvv = {dvv[9:0], dn[0]};
      if (k == 3) din_a[0] = 8'h00;
    end
    chk("A5 bits", 64'(sv), 64'(10'b0101001011));
    chk("A5 busy", 64'(bv), 64'(11'b11111111110));
    chk("A5 done", 64'(dvv), 64'(11'b00000000001));
    cyc(5);

    // LSB first, 01
    din_a[1] = 8'h01; dv[1] = 1'b1;
    sv = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) dv[1] = 1'b0;
      sv = {sv[8:0], so[1]};
    end
    chk("01 lsb bits", 64'(sv), 64'(10'b0100000001));
    cyc(5);

    // BIT_CYCLES=4, FF
    din_a[2] = 8'hFF; dv[2] = 1'b1;
    lo = 0; hi = 0; bc = 0; dc = 0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1) dv[2] = 1'b0;
      if (bz[2] && !so[2]) lo++;
      if (bz[2] && so[2]) hi++;
      if (bz[2]) bc++;
      if (dn[2]) dc++;
      if (k <= 4) chk("FF start low", 64'(so[2]), 64'd0);
    end
    chk("FF low cycles", 64'(lo), 64'd4);
    chk("FF high cycles", 64'(hi), 64'd36);
    chk("FF frame len", 64'(bc), 64'd40);
    chk("FF done width", 64'(dc), 64'd1);
    cyc(5);

    // back-to-back 3C then C3 with din_valid held
    din_a[0] = 8'h3C; dv[0] = 1'b1;
    sv = '0; sv2 = '0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) din_a[0] = 8'hC3;
      if (k <= 10) sv = {sv[8:0], so[0]};
      if (k == 11) begin
        chk("gap sout", 64'(so[0]), 64'd1);
        chk("gap ready", 64'(rd[0]), 64'd1);
        chk("gap busy", 64'(bz[0]), 64'd0);
      end
      if (k >= 12) sv2 = {sv2[8:0], so[0]};
      if (k == 21) dv[0] = 1'b0;
    end
    chk("b2b first", 64'(sv), 64'(10'b0001111001));
    chk("b2b second", 64'(sv2), 64'(10'b0110000111));
    cyc(5);

    // reset during data bit 3
    din_a[0] = 8'hA5; dv[0] = 1'b1;
    cyc(1);
    dv[0] = 1'b0;
    cyc(4);
    #2 rst = 1'b1;
    #1;
    chk("abort sout", 64'(so[0]), 64'd1);
    chk("abort busy", 64'(bz[0]), 64'd0);
    chk("abort ready", 64'(rd[0]), 64'd0);
    chk("abort done", 64'(dn[0]), 64'd0);
    cyc(1);
    #2 rst = 1'b0;
    cyc(1);
    chk("post-abort ready", 64'(rd[0]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("post-abort no done", 64'(dn[0]), 64'd0);
      cyc(1);
    end
    din_a[0] = 8'h5A; dv[0] = 1'b1;
    sv = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) dv[0] = 1'b0;
      sv = {sv[8:0], so[0]};
    end
    chk("post-abort 5A", 64'(sv), 64'(10'b0010110101));
    cyc(45);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        dv[i] = ($urandom_range(0, 3) != 0);
        din_a[i] = 8'($urandom);
      end
    end
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sreg_piso_tx.md
SREG_PISO_TX -- requirements
Module: sreg_piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the number of data bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter BIT_CYCLES, default 1, which sets the sys_clk cycles per serial bit (legal range 1..256).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, where 1 sends din[WIDTH-1] first and 0 sends din[0] first.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port din, input, WIDTH bits: the parallel word to transmit.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for transmission.
REQ-008 The block SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The block SHALL have port sout, output, 1 bit: the serial line, which idles at 1.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress (any state other than IDLE).
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 The FSM SHALL have the states IDLE, START, DATA and STOP and no others.
REQ-014 din_ready SHALL be 1 only in IDLE and SHALL be 0 in START, DATA and STOP.
REQ-015 A transfer SHALL occur on the rising edge where din_valid=1 and din_ready=1; on that edge din is copied into an internal shift register and the FSM moves to START.
REQ-016 din and din_valid SHALL be ignored outside IDLE: no word is latched, and changing din mid-frame has no effect on sout.
REQ-017 Frame format SHALL be: start bit 0, then WIDTH data bits in MSB_FIRST order, then stop bit 1; each bit lasts exactly BIT_CYCLES cycles.
REQ-018 sout SHALL drive the start bit from the first cycle after the transfer edge, with one cycle of latency.
REQ-019 A bit-cycle counter SHALL count 0..BIT_CYCLES-1 and wrap to 0 at each bit boundary; a bit counter SHALL count 0..WIDTH-1 in DATA.
REQ-020 On the last cycle of the START bit the FSM SHALL go to DATA, and sout SHALL present the first data bit.
REQ-021 On the last cycle of data bit WIDTH-1 the FSM SHALL go to STOP, with no extra data bit and no skipped data bit.
REQ-022 On the last cycle of the STOP bit the FSM SHALL go to IDLE.
REQ-023 done SHALL be 1 for exactly the first IDLE cycle after STOP, and din_ready SHALL also be 1 in that cycle.
REQ-024 The total frame length SHALL be (WIDTH+2)*BIT_CYCLES cycles, measured from the first start-bit cycle to the last stop-bit cycle.
REQ-025 Back-to-back frames SHALL be spaced at a minimum of one IDLE cycle between the stop bit and the next start bit.
REQ-026 If din_valid is held at 1 continuously, the block SHALL accept a new word on every first IDLE cycle.
REQ-027 When WIDTH=1, the DATA state SHALL last exactly one bit period.
REQ-028 When BIT_CYCLES=1, each state SHALL advance every cycle.
REQ-029 busy SHALL equal (state != IDLE), registered together with the state.

Reset
REQ-030 While sys_rst_n=1, the block SHALL force asynchronously: state=IDLE, sout=1, din_ready=0, busy=0, done=0, counters=0, shift register=0.
REQ-031 A reset asserted mid-frame SHALL abort the frame immediately, with sout returning to 1 within the same cycle and no done pulse.
REQ-032 After sys_rst_n falls to 0, din_ready SHALL rise to 1 on the first rising edge of sys_clk.
REQ-033 After reset, the block SHALL accept no word until din_ready has been observed as 1.

Verification
REQ-034 The bench SHALL cover: defaults, din=8'hA5 accepted at edge T -> sout from T+1 is 0,1,0,1,0,0,1,0,1,1 (one cycle each); done=1 at T+11; busy=1 from T+1 to T+10.
REQ-035 The bench SHALL cover: MSB_FIRST=0, din=8'h01 -> sout is 0,1,0,0,0,0,0,0,0,1.
REQ-036 The bench SHALL cover: BIT_CYCLES=4, din=8'hFF -> start low for 4 cycles, then sout high for 36 cycles; frame length 40 cycles; done pulse lasts 1 cycle.
REQ-037 The bench SHALL cover: din_valid held at 1 with words 8'h3C then 8'hC3 -> two complete frames with exactly one IDLE cycle (sout=1, din_ready=1) between them, and the second frame carries 8'hC3.
REQ-038 The bench SHALL cover: din changed to 8'h00 while the 8'hA5 frame is in DATA -> the transmitted bits remain those of 8'hA5.
REQ-039 The bench SHALL cover: sys_rst_n pulsed to 1 during data bit 3 -> sout=1, busy=0 and din_ready=0 immediately; no done pulse; after release, din_ready=1 on the next edge and a new frame transmits correctly.
